memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage pipeline, between the EX/MEM register and the WriteBack stage.
- Holds a word-organised data memory and performs loads and stores, including byte and halfword stores.
- Returns load data left-aligned, so the addressed byte sits in [31:24] and the addressed halfword in [31:16]. WriteBack then extracts it by right shift.
- Registers the MEM/WB pipeline outputs.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in data memory.
- ADDR_W, 8, word-index width; equals log2(MEM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inEnable  in  1  pipeline advance (0 = debug-unit step hold).
- inMEM  in  4  [0] MemRead, [1] MemWrite, [2] byte size, [3] halfword size (neither set = word).
- inWB  in  5  WB control: [0] MemtoReg, [1] RegWrite, [2] byte, [3] halfword, [4] signed.
- inALUResult  in  32  effective address / ALU result.
- inRegB  in  32  store data.
- inRd  in  5  destination register.
- inDebugAddr  in  ADDR_W  debug word index.
- outWB  out  5  registered WB control.
- outRegF_wd  out  32  registered, left-aligned load data.
- outALUResult  out  32  registered ALU result.
- outRd  out  5  registered destination.
- outMisaligned  out  1  sticky misaligned-access flag.
- outDebugData  out  32  memory word at inDebugAddr.

Behaviour:
- Reset: all registered outputs are 0, including outMisaligned.
  - Data memory contents are not affected by rst; simulation initialises them to 0.
  - rst takes priority over inEnable.
- Addressing:
  - word index = inALUResult[ADDR_W+1:2]; offset k = inALUResult[1:0]; upper address bits are ignored (wrap).
  - Big-endian within the word: offset 0 is bits [31:24].
- Misalignment, defined as `mis`:
  - `mis` is set when (MemRead or MemWrite) and one of: halfword with k[0]=1, or word with k != 0.
  - Byte accesses are never misaligned.
- Store (rising edge, inEnable=1, MemWrite=1, !mis):
  - byte: write inRegB[7:0] into lane bits [31-8k -: 8].
  - halfword: write inRegB[15:0] into [31:16] (k=0) or [15:0] (k=2).
  - word: write all 32 bits.
  - Other lanes are unchanged.
- Load data: combinational read of the addressed word, shifted left by 8*k, is latched into outRegF_wd.
  - When MemRead=0 or mis, 0 is latched.
- Read-after-write ordering: a load in cycle N+1 sees a store committed in cycle N. A same-cycle store and load is impossible (one instruction per stage).
- Pipeline register (rising edge, inEnable=1):
  - outWB <= inWB, except bit 1 is forced 0 when mis.
  - outALUResult <= inALUResult; outRd <= inRd.
  - outMisaligned <= outMisaligned | mis.
- inEnable=0: no memory write, all registers hold.
- Latency: 1 cycle from EX/MEM inputs to outputs.
- Debug port: outDebugData = mem[inDebugAddr], combinational, with no effect on the pipeline.
- MemWrite and MemRead both set is treated as a store only; outRegF_wd latches 0.

Decomposition:
- Shared package/include:
  - inMEM bit indices (MEM_READ=0, MEM_WRITE=1, MEM_BYTE=2, MEM_HALF=3).
  - inWB bit indices (WB_MEMTOREG=0, WB_REGWRITE=1, WB_BYTE=2, WB_HALF=3, WB_SIGNED=4).
- One sub-module: data_memory. It contains the word array, the byte-lane write-enable and merge logic, the combinational read port and the debug read port.
- memory_access keeps the address decode, the misalignment check, load alignment and the MEM/WB register.

Test Plan:
- Reset, then store word 0xDEADBEEF at addr 0x10, load word at 0x10 next cycle.
  - outRegF_wd=0xDEADBEEF and outWB matches inWB after 1 cycle.
- Store byte 0x5A at addr 0x13 over 0x11223344.
  - outDebugData(idx 4)=0x1122335A.
  - Load byte at 0x13 gives outRegF_wd=0x5A000000.
- Store halfword 0xBEEF at 0x22 over 0, load halfword at 0x22.
  - Load returns outRegF_wd=0xBEEF0000.
  - The same load with inWB=5'b11011 gives WriteBack result 0xFFFFBEEF.
- Halfword store at 0x21.
  - Memory unchanged, outMisaligned=1 and stays 1, outWB[1]=0 for that instruction.
  - outMisaligned clears only on rst.
- inEnable=0 with a store to 0x30 pending.
  - No write, outputs hold.
  - Raising inEnable commits the store once.
- rst asserted together with inEnable=1 and a load.
  - All registered outputs become 0.
  - Memory contents before rst are still readable via the debug port.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access shared definitions
// control bit indices and access-size decode
package memory_access_pkg;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_BYTE  = 2;
  localparam int MEM_HALF  = 3;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_BYTE     = 2;
  localparam int WB_HALF     = 3;
  localparam int WB_SIGNED   = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } accSize_t;

  // byte wins if both size bits are set
  function automatic accSize_t decodeSize(
    input logic [3:0] memCtl
  );
    accSize_t sz;
    if (memCtl[MEM_BYTE])
      sz = SZ_BYTE;
    else if (memCtl[MEM_HALF])
      sz = SZ_HALF;
    else
      sz = SZ_WORD;
    return sz;
  endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// data_memory: word array with byte-lane stores
// one combinational read port plus a debug read port
module data_memory
  import memory_access_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  accSize_t          size,
  input  logic [1:0]        offset,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wrData,
  output logic [31:0]       rdData,
  input  logic [ADDR_W-1:0] debugAddr,
  output logic [31:0]       debugData
);

  logic [31:0] mem [MEM_DEPTH];
  logic [3:0]  laneEn;
  logic [31:0] laneData;
  logic [31:0] merged;

  // lane select, bit 3 is the big-endian byte 0
  always_comb begin
    laneEn   = 4'b0000;
    laneData = 32'h0;
    case (size)
      SZ_BYTE: begin
        laneEn   = 4'b1000 >> offset;
        laneData = {4{wrData[7:0]}};
      end
      SZ_HALF: begin
        laneEn   = offset[1] ? 4'b0011 : 4'b1100;
        laneData = {2{wrData[15:0]}};
      end
      default: begin
        laneEn   = 4'b1111;
        laneData = wrData;
      end
    endcase
  end

  assign rdData    = mem[idx];
  assign debugData = mem[debugAddr];

  // merge new lanes into the old word
  always_comb begin
    merged = rdData;
    for (int i = 0; i < 4; i++) begin
      if (laneEn[i])
        merged[8*i +: 8] = laneData[8*i +: 8];
    end
  end

  // commit the merged word
  always_ff @(posedge clk) begin
    if (wrEn)
      mem[idx] <= merged;
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage of the pipeline
// loads/stores, alignment check and MEM/WB register
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inEnable,
  input  logic [3:0]        inMEM,
  input  logic [4:0]        inWB,
  input  logic [31:0]       inALUResult,
  input  logic [31:0]       inRegB,
  input  logic [4:0]        inRd,
  input  logic [ADDR_W-1:0] inDebugAddr,
  output logic [4:0]        outWB,
  output logic [31:0]       outRegF_wd,
  output logic [31:0]       outALUResult,
  output logic [4:0]        outRd,
  output logic              outMisaligned,
  output logic [31:0]       outDebugData
);

  accSize_t          size;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] idx;
  logic              memRead;
  logic              memWrite;
  logic              mis;
  logic              wrEn;
  logic [31:0]       rdData;
  logic [31:0]       loadData;
  logic [4:0]        wbNext;
  logic              unusedAddr;

  assign size     = decodeSize(inMEM);
  assign offset   = inALUResult[1:0];
  assign idx      = inALUResult[ADDR_W+1:2];
  assign memRead  = inMEM[MEM_READ];
  assign memWrite = inMEM[MEM_WRITE];

  // high address bits wrap
  assign unusedAddr = ^inALUResult[31:ADDR_W+2];

  // halfwords need k[0]=0, words need k=0
  always_comb begin
    mis = 1'b0;
    if (memRead || memWrite) begin
      case (size)
        SZ_HALF: mis = offset[0];
        SZ_WORD: mis = |offset;
        default: mis = 1'b0;
      endcase
    end
  end

  assign wrEn = inEnable && !rst
             && memWrite && !mis;

  data_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) uMem (
    .clk       (clk),
    .wrEn      (wrEn),
    .size      (size),
    .offset    (offset),
    .idx       (idx),
    .wrData    (inRegB),
    .rdData    (rdData),
    .debugAddr (inDebugAddr),
    .debugData (outDebugData)
  );

  // left-align; a store wins over a load
  always_comb begin
    loadData = 32'h0;
    if (memRead && !memWrite && !mis)
      loadData = rdData << {offset, 3'b000};
  end

  // a faulting access must not write a register
  always_comb begin
    wbNext = inWB;
    wbNext[WB_REGWRITE] = inWB[WB_REGWRITE] & ~mis;
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      outWB         <= 5'h0;
      outRegF_wd    <= 32'h0;
      outALUResult  <= 32'h0;
      outRd         <= 5'h0;
      outMisaligned <= 1'b0;
    end else if (inEnable) begin
      outWB         <= wbNext;
      outRegF_wd    <= loadData;
      outALUResult  <= inALUResult;
      outRd         <= inRd;
      outMisaligned <= outMisaligned | mis;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench
// byte-array reference model, random plus directed stimulus
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inEnable = 1'b0;
  logic [3:0]  inMEM = 4'h0;
  logic [4:0]  inWB = 5'h0;
  logic [31:0] inALUResult = 32'h0;
  logic [31:0] inRegB = 32'h0;
  logic [4:0]  inRd = 5'h0;
  logic [7:0]  inDebugAddr = 8'h0;
  logic [4:0]  outWB;
  logic [31:0] outRegF_wd;
  logic [31:0] outALUResult;
  logic [4:0]  outRd;
  logic        outMisaligned;
  logic [31:0] outDebugData;

  memory_access dut (
    .clk           (clk),
    .rst           (rst),
    .inEnable      (inEnable),
    .inMEM         (inMEM),
    .inWB          (inWB),
    .inALUResult   (inALUResult),
    .inRegB        (inRegB),
    .inRd          (inRd),
    .inDebugAddr   (inDebugAddr),
    .outWB         (outWB),
    .outRegF_wd    (outRegF_wd),
    .outALUResult  (outALUResult),
    .outRd         (outRd),
    .outMisaligned (outMisaligned),
    .outDebugData  (outDebugData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wb;
    logic [31:0] wd;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [1024];
  logic        stickyM = 1'b0;
  logic [31:0] expDbg = 32'h0;
  bit          memKnown = 1'b0;
  int          nVec = 0;
  int          nFail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // drive one stage input set and predict its result
  task automatic issue(input bit r, input bit en,
                       input logic [3:0] m,
                       input logic [4:0] wb,
                       input logic [31:0] alu,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic [7:0] dbg);
    exp_t e;
    int n, k, base;
    bit isRd, isWr, mis;
    @(negedge clk);
    rst = r;
    inEnable = en;
    inMEM = m;
    inWB = wb;
    inALUResult = alu;
    inRegB = b;
    inRd = rd;
    inDebugAddr = dbg;
    if (r) begin
      stickyM = 1'b0;
    end else if (en) begin
      n = m[2] ? 1 : (m[3] ? 2 : 4);
      k = int'(alu[1:0]);
      base = int'(alu[9:2]) * 4;
      isRd = m[0];
      isWr = m[1];
      mis = (isRd || isWr) && (k % n != 0);
      e.wd = 32'h0;
      if (isWr && !mis) begin
        for (int j = 0; j < n; j++)
          mb[base+k+j] = 8'(b >> (8*(n-1-j)));
      end else if (isRd && !mis) begin
        for (int j = 0; j < 4 - k; j++)
          e.wd[31-8*j -: 8] = mb[base+k+j];
      end
      stickyM = stickyM | mis;
      e.wb = wb;
      if (mis) e.wb[1] = 1'b0;
      e.alu = alu;
      e.rd = rd;
      e.mis = stickyM;
      q.push_back(e);
    end
    expDbg = {mb[4*dbg], mb[4*dbg+1],
              mb[4*dbg+2], mb[4*dbg+3]};
  endtask

  // monitor: pop on advance, expect hold otherwise
  initial begin
    exp_t last;
    bit sr, se;
    last = '{wb: 0, wd: 0, alu: 0, rd: 0, mis: 0};
    forever begin
      @(posedge clk);
      sr = rst;
      se = inEnable;
      #1;
      if (sr) begin
        last = '{wb: 0, wd: 0, alu: 0, rd: 0, mis: 0};
      end else if (se) begin
        if (q.size() == 0) begin
          nVec++;
          nFail++;
          $display("FAIL scoreboard: empty queue");
        end else begin
          last = q.pop_front();
        end
      end
      check("outWB", 32'(outWB), 32'(last.wb));
      check("outRegF_wd", outRegF_wd, last.wd);
      check("outALUResult", outALUResult, last.alu);
      check("outRd", 32'(outRd), 32'(last.rd));
      check("outMisaligned", 32'(outMisaligned),
            32'(last.mis));
      if (memKnown)
        check("outDebugData", outDebugData, expDbg);
    end
  end

  initial begin
    logic [3:0] m;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h0;

    issue(1, 0, 4'h0, 5'h0, 0, 0, 0, 0);
    issue(1, 1, 4'h1, 5'h3, 32'h10, 0, 5'd1, 0);

    for (int i = 0; i < 256; i++)
      issue(0, 1, 4'b0010, 5'h0, 32'(i*4), 0, 0, 0);
    memKnown = 1'b1;

    issue(0, 1, 4'b0010, 5'h0, 32'h10,
          32'hDEADBEEF, 5'd0, 8'd4);
    issue(0, 1, 4'b0001, 5'b00011, 32'h10,
          0, 5'd7, 8'd4);
    issue(0, 1, 4'b0010, 5'h0, 32'h10,
          32'h11223344, 5'd0, 8'd4);
    issue(0, 1, 4'b0110, 5'h0, 32'h13,
          32'h0000005A, 5'd0, 8'd4);
    @(posedge clk); #2;
    check("dbg_byte_store", outDebugData, 32'h1122335A);
    issue(0, 1, 4'b0101, 5'b00111, 32'h13,
          0, 5'd3, 8'd4);
    @(posedge clk); #2;
    check("load_byte", outRegF_wd, 32'h5A000000);

    issue(0, 1, 4'b1010, 5'h0, 32'h22,
          32'h0000BEEF, 5'd0, 8'd8);
    issue(0, 1, 4'b1001, 5'b11011, 32'h22,
          0, 5'd9, 8'd8);
    @(posedge clk); #2;
    check("load_half", outRegF_wd, 32'hBEEF0000);
    check("wb_sext", 32'($signed(outRegF_wd) >>> 16),
          32'hFFFFBEEF);

    issue(0, 1, 4'b1010, 5'b00010, 32'h21,
          32'h00001234, 5'd4, 8'd8);
    @(posedge clk); #2;
    check("mis_flag", 32'(outMisaligned), 32'h1);
    check("mis_regwrite", 32'(outWB[1]), 32'h0);
    check("mis_nowrite", outDebugData, 32'h0000BEEF);
    issue(0, 1, 4'b0001, 5'b00011, 32'h20,
          0, 5'd5, 8'd8);

    for (int i = 0; i < 3; i++)
      issue(0, 0, 4'b0010, 5'h2, 32'h30,
            32'hCAFEF00D, 5'd6, 8'd12);
    issue(0, 1, 4'b0010, 5'h2, 32'h30,
          32'hCAFEF00D, 5'd6, 8'd12);
    issue(0, 1, 4'b0001, 5'h3, 32'h30,
          0, 5'd6, 8'd12);

    for (int i = 0; i < 500; i++) begin
      m = 4'h0;
      case ($urandom_range(0, 3))
        0: m[0] = 1'b1;
        1: m[1] = 1'b1;
        2: m[1:0] = 2'b11;
        default: m = 4'h0;
      endcase
      case ($urandom_range(0, 2))
        0: m[2] = 1'b1;
        1: m[3] = 1'b1;
        default: ;
      endcase
      a = ($urandom_range(0, 3) == 0)
          ? $urandom : 32'($urandom_range(0, 63));
      issue(0, $urandom_range(0, 7) != 0, m,
            5'($urandom), a, $urandom,
            5'($urandom), 8'($urandom_range(0, 15)));
    end

    issue(1, 1, 4'b0001, 5'h3, 32'h10,
          0, 5'd2, 8'd12);
    issue(0, 0, 4'h0, 5'h0, 0, 0, 0, 8'd4);
    issue(0, 0, 4'h0, 5'h0, 0, 0, 0, 8'd12);
    @(posedge clk); #3;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nFail);
    $finish;
  end

endmodule
